// File: rtl/demux_32_buf_pkg.sv
// rtl/demux_32_buf_pkg.sv - shared constants and helpers for the 32-bit buffered demux
package demux_32_buf_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;
  localparam int NCH    = 8;
  localparam int OCC_W  = 4;

  function automatic logic [OCC_W-1:0] count_ones(input logic [NCH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt = cnt + OCC_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/demux1_to_8.sv
// rtl/demux1_to_8.sv - decodes a channel select plus strobe into a one-hot write enable
module demux1_to_8
  import demux_32_buf_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [NCH-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_32_buf.sv
// rtl/demux_32_buf.sv - distributes a 32-bit word to one of eight one-entry channel buffers
module demux_32_buf
  import demux_32_buf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ack,
  output logic [OCC_W-1:0]      occ
);

  logic [NCH-1:0]   r_valid;
  logic [OCC_W-1:0] r_occ;
  logic             w_accept;
  logic [NCH-1:0]   w_wr_en;
  logic [NCH-1:0]   w_drain;

  // A full channel can still take a word when its consumer drains it on the same edge.
  assign in_ready = ~r_valid[sel] | out_ack[sel];
  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_valid & out_ack;

  demux1_to_8 u_demux (
    .i_sel    (sel),
    .i_en     (w_accept),
    .o_onehot (w_wr_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_occ   <= '0;
    end else begin
      r_valid <= (r_valid & ~w_drain) | w_wr_en;
      r_occ   <= r_occ + OCC_W'(w_accept) - count_ones(w_drain);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DATA_W-1:0] r_buf;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_buf <= '0;
      end else if (w_wr_en[g]) begin
        r_buf <= in_data;
      end
    end

    assign out_data[g*DATA_W +: DATA_W] = r_buf;
  end

  assign out_valid = r_valid;
  assign occ       = r_occ;

endmodule
